// File: rtl/serial_sub_pkg.sv
`default_nettype none
// ============================================================================
// Module   : serial_sub_pkg
// Purpose  : Shared state encoding and default width for the serial subtractor.
// Revision : 1.0
// ============================================================================
package serial_sub_pkg;

    localparam int SUB_W_DEF = 8;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_FIN  = 2'd2;

endpackage
`default_nettype wire

// File: rtl/full_sub_bit.sv
`default_nettype none
// ============================================================================
// Module   : full_sub_bit
// Purpose  : One-bit full subtractor built from two cascaded half subtractors.
// Revision : 1.0
// ============================================================================
module full_sub_bit (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    logic w_d1;
    logic w_bout1;
    logic w_bout2;

    // First stage subtracts b from a, second stage subtracts the incoming borrow.
    assign w_d1    = a ^ b;
    assign w_bout1 = ~a & b;
    assign d       = w_d1 ^ bin;
    assign w_bout2 = ~w_d1 & bin;
    assign bout    = w_bout1 | w_bout2;

endmodule
`default_nettype wire

// File: rtl/serial_sub_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : serial_sub_ctrl
// Purpose  : Bit-serial A - B controller, LSB first, with start/done handshake.
// Revision : 1.0
// ============================================================================
module serial_sub_ctrl
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = SUB_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borr_out
);

    localparam int               CNT_W  = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_sa;
    logic [WIDTH-1:0] r_sb;
    logic [WIDTH-1:0] r_res;
    logic [WIDTH-1:0] w_res_nxt;
    logic             r_borrow;
    logic [CNT_W-1:0] r_idx;
    logic [WIDTH-1:0] r_diff;
    logic             r_borr_out;
    logic             w_d;
    logic             w_bo;
    logic             w_last;

    full_sub_bit u_full_sub_bit (
        .a    (r_sa[0]),
        .b    (r_sb[0]),
        .bin  (r_borrow),
        .d    (w_d),
        .bout (w_bo)
    );

    assign w_last = (r_idx == C_LAST);

    // New bit enters at the MSB so that after WIDTH shifts bit i lands at position i.
    if (WIDTH == 1) begin : g_res_w1
        assign w_res_nxt = w_d;
    end else begin : g_res_wn
        assign w_res_nxt = {w_d, r_res[WIDTH-1:1]};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        ready       = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                ready = 1'b1;
                if (start) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                if (w_last) begin
                    w_state_nxt = ST_FIN;
                end
            end
            ST_FIN: begin
                done        = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sa       <= '0;
            r_sb       <= '0;
            r_res      <= '0;
            r_borrow   <= 1'b0;
            r_idx      <= '0;
            r_diff     <= '0;
            r_borr_out <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_sa     <= a;
                        r_sb     <= b;
                        r_res    <= '0;
                        r_borrow <= 1'b0;
                        r_idx    <= '0;
                    end
                end
                ST_RUN: begin
                    r_sa     <= r_sa >> 1;
                    r_sb     <= r_sb >> 1;
                    r_res    <= w_res_nxt;
                    r_borrow <= w_bo;
                    r_idx    <= r_idx + CNT_W'(1);
                    // Published result only moves on the edge that raises done.
                    if (w_last) begin
                        r_diff     <= w_res_nxt;
                        r_borr_out <= w_bo;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign diff     = r_diff;
    assign borr_out = r_borr_out;

endmodule
`default_nettype wire

// File: doc/serial_sub_ctrl.md
Name: serial_sub_ctrl

Overview:
- Bit-serial subtraction controller. Computes A − B for WIDTH-bit unsigned operands, one bit per clock, LSB first.
- Uses a single one-bit full-subtractor cell built from two half-subtractor stages, plus a registered borrow.
- Trades area for latency. Used wherever a wide subtract is needed infrequently.
- Provides a start/done handshake and holds the last result until the next accepted start.

Parameters:
- WIDTH, 8, operand and result width in bits (legal range 1..32)
- CNT_W, $clog2(WIDTH)+1, bit-index counter width (derived; not overridden)

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  synchronous active-low reset
- start  input  1  request a subtraction; sampled only when ready=1
- a  input  WIDTH  minuend; captured on accepted start
- b  input  WIDTH  subtrahend; captured on accepted start
- ready  output  1  controller idle, start will be accepted
- busy  output  1  subtraction in progress
- done  output  1  one-cycle pulse: diff/borr_out valid and updated
- diff  output  WIDTH  result A − B, modulo 2^WIDTH
- borr_out  output  1  final borrow; 1 when A < B

Behaviour:
- Reset is synchronous, active-low, and highest priority. On any edge with rst_n=0:
  - state=IDLE
  - ready=1, busy=0, done=0
  - diff=0, borr_out=0
  - internal shift registers, borrow register and bit counter cleared
- A reset mid-operation aborts the operation. No done pulse is issued.
- FSM states: IDLE, RUN, FIN.
- IDLE:
  - ready=1.
  - start=1 at edge k: capture a→sa and b→sb, borrow←0, idx←0, state→RUN.
  - start=0: stay in IDLE.
- RUN:
  - busy=1, ready=0. start is ignored.
  - At edge k+1+i (i = 0..WIDTH-1), process bit i:
    - d = sa[0]^sb[0]^borrow
    - bo = (~sa[0]&sb[0]) | (~(sa[0]^sb[0])&borrow)
    - borrow←bo
    - sa, sb shift right by one
    - d shifted into result register at MSB; after WIDTH shifts bit i sits at position i
    - idx←idx+1
  - At the edge processing bit WIDTH-1: state→FIN, diff←final result, borr_out←bo, done←1.
- FIN:
  - Lasts exactly one cycle. done=1, busy=0, ready=0. start is ignored.
  - Next edge: done←0, state→IDLE.
- Latency: start accepted at edge k → done high during cycle after edge k+WIDTH. A new start is accepted at earliest edge k+WIDTH+2.
- Throughput: one result per WIDTH+2 cycles.
- diff and borr_out change only on the edge that sets done. They hold otherwise, including while a later operation is in RUN.
- Arithmetic: two's-complement wrap. diff = (A − B) mod 2^WIDTH; borr_out = (A < B).
- WIDTH=1: RUN lasts one cycle; done is asserted 1 edge after the start edge.
- Operand inputs a and b are don't-care except on the accepting edge.
- The internal borrow register is never visible externally except through borr_out.

Decomposition:
- Shared package serial_sub_pkg holds:
  - state encoding localparams: ST_IDLE=2'd0, ST_RUN=2'd1, ST_FIN=2'd2
  - default width constant SUB_W_DEF=8
- Natural sub-module: full_sub_bit.
  - Purely combinational: inputs a, b, bin; outputs d, bout.
  - Implemented as two cascaded half-subtractor stages with bout = bout1 | bout2.
- serial_sub_ctrl contains the FSM, shift registers, bit counter, borrow flop and result registers.

Test Plan:
- WIDTH=8, a=0x5A, b=0x3C, start 1 cycle:
  - done pulses exactly 8 edges after acceptance
  - diff=0x1E, borr_out=0
  - busy high 8 cycles
- a=0x00, b=0x01: diff=0xFF, borr_out=1. Then a=0x80, b=0x80: diff=0x00, borr_out=0 (full borrow ripple and equal operands).
- start held high continuously with a=0xFF, b=0x0F:
  - first op gives diff=0xF0, borr_out=0
  - start is ignored in RUN/FIN
  - second op accepted on the edge after FIN; done period = 10 cycles
- Mid-run operand change: a/b changed to 0x00 during RUN of 0x5A−0x3C → result still 0x1E. Previous result holds stable until new done.
- Reset: rst_n=0 on the 4th RUN cycle → next cycle ready=1, busy=0, done=0, diff=0, borr_out=0, no done pulse. A fresh start then completes normally.
- WIDTH=1 build, all four (a,b) combinations:
  - (0,0)→0/0, (0,1)→1/1, (1,0)→1/0, (1,1)→0/0
  - done asserted 1 edge after acceptance
